// File: rtl/rr_mux_n.sv
// rr_mux_n: N-to-1 round-robin arbiter mux with valid/ready handshakes and a registered output.
// Optional RRMUX_FORCE_SEL_EN adds force_en/force_sel to restrict grants to one channel.
module rr_mux_n #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef RRMUX_FORCE_SEL_EN
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_sel,
`endif
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
);
  logic [SELW-1:0]  ptr, gnt;
  logic [N-1:0]     elig;
  logic [WIDTH-1:0] gnt_data;
  logic             hit, load;
`ifdef RRMUX_FORCE_SEL_EN
  assign elig = in_valid & (force_en ? N'(1) << force_sel : '1);
`else
  assign elig = in_valid;
`endif
  assign load = !out_valid || out_ready;
  assign in_ready = (!rst && load && hit) ? N'(1) << gnt : '0;
  // Descending scans leave the lowest eligible index; channels above ptr override those at or below it.
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    gnt_data = '0;
    for (int i = N - 1; i >= 0; i--)
      if (elig[i] && i <= int'(ptr)) begin
        hit = 1'b1;
        gnt = SELW'(i);
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    for (int i = N - 1; i >= 0; i--)
      if (elig[i] && i > int'(ptr)) begin
        hit = 1'b1;
        gnt = SELW'(i);
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= SELW'(N - 1);
    end else if (load) begin
      out_valid <= hit;
      if (hit) begin
        out_data <= gnt_data;
        out_sel <= gnt;
        ptr <= gnt;
      end
    end
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed self-checking bench for rr_mux_n (N=4 and N=3 instances).
module tb_rr_mux_n;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [1:0]  out_sel;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3, out_ready3;
  logic [1:0]  out_sel3;
`ifdef RRMUX_FORCE_SEL_EN
  logic        force_en, force_en3;
  logic [1:0]  force_sel, force_sel3;
`endif
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rr_mux_n #(.N(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
`ifdef RRMUX_FORCE_SEL_EN
    .force_en(force_en), .force_sel(force_sel),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  rr_mux_n #(.N(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst),
`ifdef RRMUX_FORCE_SEL_EN
    .force_en(force_en3), .force_sel(force_sel3),
`endif
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_sel(out_sel3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_valid = '0;
    out_ready = 1'b1;
    in_data3 = '0;
    in_valid3 = '0;
    out_ready3 = 1'b1;
`ifdef RRMUX_FORCE_SEL_EN
    force_en = 1'b0;
    force_sel = '0;
    force_en3 = 1'b0;
    force_sel3 = '0;
`endif
    #1;
    chk("rst_in_ready", in_ready, 0);
    tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("idle_in_ready", in_ready, 0);
      tick;
      chk("idle_valid", out_valid, 0);
      chk("idle_data", out_data, 0);
      chk("idle_sel", out_sel, 0);
    end
    // all four channels valid: grants rotate 0,1,2,3,0
    in_data = 32'hA3A2A1A0;
    in_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rot_in_ready", in_ready, 32'd1 << (k % 4));
      tick;
      chk("rot_valid", out_valid, 1);
      chk("rot_data", out_data, 32'hA0 + (k % 4));
      chk("rot_sel", out_sel, k % 4);
    end
    // stall with a buffered word from channel 2
    rst = 1'b1;
    in_valid = '0;
    tick;
    rst = 1'b0;
    in_data = 32'h335C0011;
    in_valid = 4'b0100;
    out_ready = 1'b0;
    #1;
    chk("load2_in_ready", in_ready, 4'b0100);
    tick;
    chk("load2_data", out_data, 8'h5C);
    chk("load2_sel", out_sel, 2);
    in_valid = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      tick;
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h5C);
    end
    out_ready = 1'b1;
    #1;
    chk("refill_in_ready", in_ready, 4'b1000);
    tick;
    chk("refill_valid", out_valid, 1);
    chk("refill_data", out_data, 8'h33);
    chk("refill_sel", out_sel, 3);
    // N=3: channels 0 and 2 alternate, wrap is modulo 3
    in_data3 = 24'hC2B1C0;
    in_valid3 = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("n3_in_ready", in_ready3, (k % 2) ? 3'b100 : 3'b001);
      tick;
      chk("n3_sel", out_sel3, (k % 2) ? 2 : 0);
      chk("n3_data", out_data3, (k % 2) ? 8'hC2 : 8'hC0);
    end
    in_valid3 = '0;
    // reset while full and stalled
    out_ready = 1'b0;
    in_valid = 4'hF;
    in_data = 32'hA3A2A1A0;
    tick;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    tick;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sel", out_sel, 0);
    chk("midrst_data", out_data, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 4'b0001);
    tick;
    chk("post_rst_sel", out_sel, 0);
    chk("post_rst_data", out_data, 8'hA0);
`ifdef RRMUX_FORCE_SEL_EN
    force_en = 1'b1;
    force_sel = 2'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("force_in_ready", in_ready, 4'b0010);
      tick;
      chk("force_sel", out_sel, 1);
      chk("force_data", out_data, 8'hA1);
    end
    force_en = 1'b0;
    #1;
    chk("unforce_in_ready", in_ready, 4'b0100);
    tick;
    chk("unforce_sel", out_sel, 2);
    force_en3 = 1'b1;
    force_sel3 = 2'd3;
    in_valid3 = 3'b111;
    #1;
    chk("force_oob_in_ready", in_ready3, 0);
    tick;
    chk("force_oob_valid", out_valid3, 0);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
